// File: rtl/pattern_sequence_detector.sv
// Parametrised serial bit-pattern detector: reloadable pattern, enable gating, fill tracking,
// saturating match counter. Define PATTERN_SEQUENCE_DETECTOR_REG_OUT_EN to register z.
module pattern_sequence_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0101,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               x,
  input  logic               en,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [PAT_LEN-1:0] pattern
);
  localparam int                FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_LEN-2:0] hist, hist_nxt;
  logic [FILL_W-1:0]  fill, fill_nxt;
  logic [PAT_LEN-1:0] pat, pat_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [PAT_LEN-1:0] window;
  logic               match;

  // The window is the stored history plus the bit arriving this cycle, so a match is zero-latency.
  assign window = {hist, x};
  assign match  = en & ~load & (fill == FILL_MAX) & (window == pat);

  always_comb begin
    pat_nxt  = pat;
    hist_nxt = hist;
    fill_nxt = fill;
    cnt_nxt  = match_cnt;
    if (load) begin
      pat_nxt  = pat_in;
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (en) begin
      if (match && !OVERLAP) begin
        hist_nxt = '0;
        fill_nxt = '0;
      end else begin
        hist_nxt = window[PAT_LEN-2:0];
        if (fill != FILL_MAX) fill_nxt = fill + 1'b1;
      end
    end
    if (match && (match_cnt != CNT_MAX)) cnt_nxt = match_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pat       <= PATTERN;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else begin
      pat       <= pat_nxt;
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      match_cnt <= cnt_nxt;
    end
  end

  assign pattern = pat;

`ifdef PATTERN_SEQUENCE_DETECTOR_REG_OUT_EN
  // Registered indication lags the completing bit by one edge; load already forces match low.
  logic z_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) z_q <= 1'b0;
    else          z_q <= match;
  end
  assign z = z_q;
`else
  assign z = match;
`endif

endmodule

// File: tb/tb_pattern_sequence_detector.sv
// Bench for pattern_sequence_detector: three instances (default, no-overlap, 2-bit counter)
// share one directed stream and are checked each cycle against a bit-count/shift model.
module tb_pattern_sequence_detector;
  localparam int N = 3;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         x = 1'b0, en = 1'b0, load = 1'b0;
  logic [3:0]   pat_in = 4'b0000;
  logic [N-1:0] z;
  logic [7:0]   cnt0, cnt1;
  logic [1:0]   cnt2;
  logic [3:0]   pat0, pat1, pat2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pattern_sequence_detector u0 (
    .clock(clock), .reset_n(reset_n), .x(x), .en(en), .load(load), .pat_in(pat_in),
    .z(z[0]), .match_cnt(cnt0), .pattern(pat0));

  pattern_sequence_detector #(.OVERLAP(1'b0)) u1 (
    .clock(clock), .reset_n(reset_n), .x(x), .en(en), .load(load), .pat_in(pat_in),
    .z(z[1]), .match_cnt(cnt1), .pattern(pat1));

  pattern_sequence_detector #(.CNT_W(2)) u2 (
    .clock(clock), .reset_n(reset_n), .x(x), .en(en), .load(load), .pat_in(pat_in),
    .z(z[2]), .match_cnt(cnt2), .pattern(pat2));

  // Model: last received bits as an integer, count of valid bits since the last clear.
  int           m_bits [N];
  int           m_seen [N];
  int           m_cnt  [N];
  int           m_pat  [N];
  logic [N-1:0] m_zreg;
  logic [N-1:0] hit;

  function automatic bit ovl(input int i);
    return i != 1;
  endfunction

  function automatic int cmax(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  function automatic bit exp_z(input int i);
    return en && !load && (m_seen[i] >= 3) && (((m_bits[i] * 2 + int'(x)) % 16) == m_pat[i]);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_bits[i] = 0; m_seen[i] = 0; m_cnt[i] = 0; m_pat[i] = 5; m_zreg[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) hit[i] = exp_z(i);
      for (int i = 0; i < N; i++) begin
        m_zreg[i] = hit[i];
        if (load) begin
          m_pat[i] = int'(pat_in); m_bits[i] = 0; m_seen[i] = 0;
        end else if (en) begin
          if (hit[i] && !ovl(i)) begin
            m_bits[i] = 0; m_seen[i] = 0;
          end else begin
            m_bits[i] = (m_bits[i] * 2 + int'(x)) % 16;
            m_seen[i] = m_seen[i] + 1;
          end
        end
        if (hit[i] && (m_cnt[i] < cmax(i))) m_cnt[i] = m_cnt[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Literal z expectations assume the zero-latency output.
  task automatic chkz(input string name, input int act, input int exp);
`ifndef PATTERN_SEQUENCE_DETECTOR_REG_OUT_EN
    chk(name, act, exp);
`endif
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
`ifdef PATTERN_SEQUENCE_DETECTOR_REG_OUT_EN
      chk($sformatf("model z[%0d]", i), int'(z[i]), int'(m_zreg[i]));
`else
      chk($sformatf("model z[%0d]", i), int'(z[i]), int'(exp_z(i)));
`endif
    end
    chk("model cnt0", int'(cnt0), m_cnt[0]);
    chk("model cnt1", int'(cnt1), m_cnt[1]);
    chk("model cnt2", int'(cnt2), m_cnt[2]);
    chk("model pat0", int'(pat0), m_pat[0]);
    chk("model pat1", int'(pat1), m_pat[1]);
    chk("model pat2", int'(pat2), m_pat[2]);
  end

  // Drive one cycle of inputs, capture z before the edge, return just after the edge.
  task automatic step(input logic xi, input logic ei, input logic li, input logic [3:0] pi,
                      output logic [N-1:0] zs);
    x = xi; en = ei; load = li; pat_in = pi;
    @(negedge clock);
    #1 zs = z;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input string name, input int inst, input int n,
                     input logic [15:0] bits, input logic [15:0] zexp);
    logic [N-1:0] zs;
    for (int k = 0; k < n; k++) begin
      step(bits[n-1-k], 1'b1, 1'b0, 4'b0000, zs);
      chkz($sformatf("%s z[%0d] bit%0d", name, inst, k + 1), int'(zs[inst]), int'(zexp[n-1-k]));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] zs;
    int           seq [5] = '{1, 2, 3, 3, 3};
    repeat (2) @(posedge clock);
    #1;
    chk("reset z", int'(z[0]), 0);
    chk("reset cnt", int'(cnt0), 0);
    chk("reset pattern", int'(pat0), 4'b0101);
    reset_n = 1'b1;

    // Overlapping detection of 0101
    run("t1", 0, 6, 16'b010101, 16'b000101);
    chk("t1 cnt", int'(cnt0), 2);

    // Non-overlapping instance discards history after each match
    do_reset();
    run("t2", 1, 8, 16'b01010101, 16'b00010001);
    chk("t2 cnt", int'(cnt1), 2);

    // Reload an all-zero pattern; the x presented with load is discarded
    step(1'b0, 1'b1, 1'b1, 4'b0000, zs);
    chkz("t3 load z", int'(zs[0]), 0);
    chk("t3 pattern", int'(pat0), 4'b0000);
    run("t3", 0, 6, 16'b000000, 16'b000111);

    // en=0 window holds state while x toggles
    do_reset();
    run("t4a", 0, 2, 16'b01, 16'b00);
    for (int k = 0; k < 3; k++) begin
      step(logic'(k % 2 == 0), 1'b0, 1'b0, 4'b0000, zs);
      chkz($sformatf("t4 idle z bit%0d", k + 1), int'(zs[0]), 0);
    end
    run("t4b", 0, 2, 16'b01, 16'b01);
    chk("t4 cnt", int'(cnt0), 1);

    // 2-bit counter saturates at 3
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(logic'(k % 2), 1'b1, 1'b0, 4'b0000, zs);
      if ((k % 2 == 1) && (k >= 3)) chk($sformatf("t5 cnt2 match%0d", (k - 1) / 2), int'(cnt2), seq[(k - 3) / 2]);
    end
    chk("t5 cnt0", int'(cnt0), 5);

    // Asynchronous reset mid-stream restores pattern and drops history
    do_reset();
    step(1'b1, 1'b1, 1'b1, 4'b0011, zs);
    chk("t6 loaded pattern", int'(pat0), 4'b0011);
    run("t6a", 0, 7, 16'b0011010, 16'b0001000);
    chk("t6 cnt before reset", int'(cnt0), 1);
    reset_n = 1'b0;
    #2;
    chk("t6 reset z", int'(z[0]), 0);
    chk("t6 reset cnt", int'(cnt0), 0);
    chk("t6 reset pattern", int'(pat0), 4'b0101);
    @(posedge clock);
    #1 reset_n = 1'b1;
    run("t6b", 0, 1, 16'b1, 16'b0);
    run("t6c", 0, 4, 16'b0101, 16'b0001);
    chk("t6 cnt after", int'(cnt0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
